receiver_fifo_axis: RTL and testbench
=====================================

# receiver_fifo_axis

Synchronous AXI-Stream FIFO placed directly downstream of the UART receiver. It absorbs received words while the consumer stalls, so the receiver never sits in its hold-word state long enough to miss the next start bit. It exposes an occupancy level and an almost-full flag for flow-control logic further down the design.

## Interface
- WORD_WIDTH, 32'd8, width of each stored word; matches the receiver word width.
- DEPTH, 32'd16, number of entries; power of two, ≥ 2.
- ALMOST_FULL_LEVEL, 32'd12, level at or above which `almost_full` asserts; 1 ≤ value ≤ DEPTH.
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- din_axis_tdata  input  WORD_WIDTH  word from the receiver.
- din_axis_tvalid  input  1  upstream word valid.
- din_axis_tready  output  1  FIFO accepts a word; equals not full.
- dout_axis_tdata  output  WORD_WIDTH  head-of-FIFO word.
- dout_axis_tvalid  output  1  FIFO non-empty.
- dout_axis_tready  input  1  downstream accepts the head word.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  output  1  level ≥ ALMOST_FULL_LEVEL.

## Operation
- Storage: DEPTH×WORD_WIDTH register array.
- Pointers: write and read pointers, each $clog2(DEPTH)+1 bits wide. The low bits index the array; the MSB is the wrap bit.
  - Empty: pointers are equal.
  - Full: index bits are equal and the MSBs differ.
- Write: when `din_axis_tvalid && din_axis_tready`, store the word at the write index and increment the write pointer (modulo 2·DEPTH).
- Read: when `dout_axis_tvalid && dout_axis_tready`, increment the read pointer (modulo 2·DEPTH).
- `dout_axis_tdata` is a combinational read of the array at the read index. It is first-word-fall-through: it shows the head word whenever `dout_axis_tvalid` is high and is don't-care when the FIFO is empty.
- `level` is a registered counter:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on simultaneous write+read or on neither.
- `din_axis_tready = ~full` and `dout_axis_tvalid = ~empty`. Both are pure functions of registered pointers. There is no combinational path from `din_axis_tvalid` or `dout_axis_tready` to any output.
- AXIS rule: once `dout_axis_tvalid` is high, it and `dout_axis_tdata` stay stable until the handshake completes.
- Reset (`rst_n` low at a rising edge) clears both pointers and `level`, whether or not a transfer is in progress. Array contents are not reset. Any in-flight word is discarded.
- Reset values of outputs:
  - `din_axis_tready` = 1.
  - `dout_axis_tvalid` = 0.
  - `level` = 0.
  - `almost_full` = 0 (ALMOST_FULL_LEVEL ≥ 1).
  - `dout_axis_tdata` = X.

## Timing
- Write latency: a word accepted at edge N is visible on `dout_axis_tvalid`/`dout_axis_tdata` after edge N; it can be read on edge N+1. There is no empty-FIFO bypass.
- Full: `din_axis_tready` = 0, so no write occurs. A read on the same edge frees a slot, and `din_axis_tready` rises after that edge. Write and read are never concurrent when full.
- Empty: `dout_axis_tvalid` = 0, so no read occurs. A write on the same edge makes the FIFO non-empty after that edge.
- Partially full with simultaneous write and read: both pointers advance and `level` is unchanged. Sustained throughput is one word per cycle.
- Wrap-around: pointer index bits roll from DEPTH−1 to 0 and the MSB toggles. Data order is preserved across the wrap.
- `almost_full` is updated in the same cycle as `level`.

## Structure
- Shared package `uart_pkg`: `clog2`-based pointer-width helper and the default WORD_WIDTH constant, shared with the receiver and transmitter.
- One sub-module `fifo_mem`: register array with one write port and one asynchronous read port. Pointer, flag and level logic stays in the top module.

## Test plan
- Reset then idle: after `rst_n` low for 2 cycles, `din_axis_tready`=1, `dout_axis_tvalid`=0, `level`=0, `almost_full`=0.
- Single word: write 8'hA5 with `dout_axis_tready`=0. The next cycle shows `dout_axis_tvalid`=1, `dout_axis_tdata`=8'hA5, `level`=1. Assert `dout_axis_tready` → `level`=0, `dout_axis_tvalid`=0.
- Fill to full (DEPTH=16): write 0x00..0x0F with no reads.
  - `almost_full` rises when `level` reaches 12.
  - `din_axis_tready`=0 when `level`=16; a 17th word held valid is not accepted.
  - Drain returns 0x00..0x0F in order.
- Simultaneous write+read at `level`=5 for 40 cycles: `level` stays 5, pointers wrap at least twice, and output order matches the input sequence.
- Full plus read: at `level`=16 with upstream valid, assert `dout_axis_tready` for one cycle. `din_axis_tready` rises the following cycle, the pending word is accepted, and `level` returns to 16.
- Reset mid-operation: at `level`=7 during simultaneous transfers, drop `rst_n` for one cycle → next cycle `level`=0, `dout_axis_tvalid`=0, `din_axis_tready`=1. The next write of 8'h3C is the next word output.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART package: word-width default and FIFO pointer-width helper,
// used by the receiver, transmitter and receiver FIFO.
package uart_pkg;

    localparam int unsigned WORD_WIDTH_DEFAULT = 8;

    // Pointer width for a power-of-two FIFO: index bits plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for the receiver FIFO: one synchronous write port
// and one asynchronous read port. Contents are intentionally not reset.
module fifo_mem #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [WORD_WIDTH-1:0] wr_data_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic [WORD_WIDTH-1:0] rd_data_o
);

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];

    // Store the incoming word at the write index on an accepted write.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Head word is read combinationally so the FIFO is first-word-fall-through.
    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/receiver_fifo_axis.sv
// AXI-Stream FIFO behind the UART receiver. Absorbs received words while the
// consumer stalls and reports occupancy plus an almost-full flag. Ready/valid
// outputs depend only on registered pointers, never on the opposite handshake.
module receiver_fifo_axis
    import uart_pkg::*;
#(
    parameter int unsigned WORD_WIDTH        = WORD_WIDTH_DEFAULT,
    parameter int unsigned DEPTH             = 16,
    parameter int unsigned ALMOST_FULL_LEVEL = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WORD_WIDTH-1:0]    din_axis_tdata,
    input  logic                     din_axis_tvalid,
    output logic                     din_axis_tready,
    output logic [WORD_WIDTH-1:0]    dout_axis_tdata,
    output logic                     dout_axis_tvalid,
    input  logic                     dout_axis_tready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] ONE    = PTR_W'(1);
    localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(ALMOST_FULL_LEVEL);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             almost_full_q, almost_full_d;

    logic full;
    logic empty;
    logic wr_en;
    logic rd_en;

    // Equal pointers mean empty; equal index with differing wrap bit means full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                   (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

    assign wr_en = din_axis_tvalid && !full;
    assign rd_en = dout_axis_tready && !empty;

    // Next-state for pointers, level and almost-full flag.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end
        if (wr_en && !rd_en) begin
            level_d = level_q + ONE;
        end else if (rd_en && !wr_en) begin
            level_d = level_q - ONE;
        end
        almost_full_d = (level_d >= AF_LVL);
    end

    // State registers; reset drops any in-flight word and empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            almost_full_q <= almost_full_d;
        end
    end

    fifo_mem #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_idx_i  (wr_ptr_q[IDX_W-1:0]),
        .wr_data_i (din_axis_tdata),
        .rd_idx_i  (rd_ptr_q[IDX_W-1:0]),
        .rd_data_o (dout_axis_tdata)
    );

    assign din_axis_tready  = !full;
    assign dout_axis_tvalid = !empty;
    assign level            = level_q;
    assign almost_full      = almost_full_q;

endmodule

// File: tb/tb_receiver_fifo_axis.sv
// Bench for receiver_fifo_axis: a table of vectors with explicit expected
// outputs, plus hand sequences for fill/drain, wrap, full+read and reset.
// A queue scoreboard holds every accepted word and predicts flags and data.
module tb_receiver_fifo_axis;

    localparam int DEPTH = 16;
    localparam int AFL   = 12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din_tdata;
    logic       din_tvalid;
    logic       din_tready;
    logic [7:0] dout_tdata;
    logic       dout_tvalid;
    logic       dout_tready;
    logic [4:0] level;
    logic       almost_full;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] sb[$];

    always #5 clk = ~clk;

    receiver_fifo_axis #(
        .WORD_WIDTH        (8),
        .DEPTH             (DEPTH),
        .ALMOST_FULL_LEVEL (AFL)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .din_axis_tdata   (din_tdata),
        .din_axis_tvalid  (din_tvalid),
        .din_axis_tready  (din_tready),
        .dout_axis_tdata  (dout_tdata),
        .dout_axis_tvalid (dout_tvalid),
        .dout_axis_tready (dout_tready),
        .level            (level),
        .almost_full      (almost_full)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compare DUT flags, level and head word against the scoreboard.
    task automatic chk_model(input string tag);
        chk({tag, " level"}, 32'(level), 32'(sb.size()));
        chk({tag, " tready"}, 32'(din_tready), 32'(sb.size() < DEPTH));
        chk({tag, " tvalid"}, 32'(dout_tvalid), 32'(sb.size() > 0));
        chk({tag, " almost_full"}, 32'(almost_full), 32'(sb.size() >= AFL));
        if (sb.size() > 0) chk({tag, " head"}, 32'(dout_tdata), 32'(sb[0]));
    endtask

    // One clock: drive inputs after the falling edge, check the word being
    // handed off, advance the scoreboard at the rising edge, check at the next fall.
    task automatic cycle(input logic rn, input logic v, input logic [7:0] d, input logic r,
                         input string tag);
        bit wr;
        bit rd;
        logic [7:0] exp_word;
        rst_n       = rn;
        din_tvalid  = v;
        din_tdata   = d;
        dout_tready = r;
        #1;
        if (!rn) begin
            sb.delete();
        end else begin
            wr = v && (sb.size() < DEPTH);
            rd = r && (sb.size() > 0);
            if (rd) begin
                exp_word = sb.pop_front();
                chk({tag, " out word"}, 32'(dout_tdata), 32'(exp_word));
            end
            if (wr) sb.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
        chk_model(tag);
        $display("%s: rst_n=%0b vld=%0b d=%02h rdy=%0b -> level=%0d in_rdy=%0b out_vld=%0b af=%0b dout=%02h",
                 tag, rn, v, d, r, level, din_tready, dout_tvalid, almost_full, dout_tdata);
    endtask

    typedef struct {
        logic       rn;
        logic       v;
        logic [7:0] d;
        logic       r;
        int         lvl;
        logic       ir;
        logic       ov;
        logic       af;
        logic [7:0] od;
    } vec_t;

    vec_t tbl[8];

    initial begin
        rst_n       = 1'b0;
        din_tvalid  = 1'b0;
        din_tdata   = 8'h00;
        dout_tready = 1'b0;

        // Reset, single word in/out, write into empty with ready high,
        // simultaneous write+read at level 1, final drain.
        tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 8'h11, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1, 1'b1, 1'b1, 1'b0, 8'hA5};
        tbl[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 1, 1'b1, 1'b1, 1'b0, 8'hA5};
        tbl[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[5] = '{1'b1, 1'b1, 8'h5A, 1'b1, 1, 1'b1, 1'b1, 1'b0, 8'h5A};
        tbl[6] = '{1'b1, 1'b1, 8'hC3, 1'b1, 1, 1'b1, 1'b1, 1'b0, 8'hC3};
        tbl[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00};

        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].rn, tbl[i].v, tbl[i].d, tbl[i].r, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("vec%0d tready", i), 32'(din_tready), 32'(tbl[i].ir));
            chk($sformatf("vec%0d tvalid", i), 32'(dout_tvalid), 32'(tbl[i].ov));
            chk($sformatf("vec%0d af", i), 32'(almost_full), 32'(tbl[i].af));
            if (tbl[i].ov) chk($sformatf("vec%0d tdata", i), 32'(dout_tdata), 32'(tbl[i].od));
        end

        // Fill to full, then hold a 17th word valid, then drain in order.
        cycle(1'b0, 1'b0, 8'h00, 1'b0, "fill rst");
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b1, 8'(i), 1'b0, $sformatf("fill%0d", i));
            if (i == AFL - 2) chk("af below 12", 32'(almost_full), 32'd0);
            if (i == AFL - 1) chk("af at 12", 32'(almost_full), 32'd1);
        end
        chk("full tready", 32'(din_tready), 32'd0);
        cycle(1'b1, 1'b1, 8'h99, 1'b0, "hold17a");
        cycle(1'b1, 1'b1, 8'h99, 1'b0, "hold17b");
        chk("full level held", 32'(level), 32'd16);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1, $sformatf("drain%0d", i));
        chk("drained level", 32'(level), 32'd0);

        // Streaming at level 5 for 40 cycles: pointers wrap twice.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'(8'h40 + i), 1'b0, $sformatf("pre%0d", i));
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b1, 8'(8'h80 + i), 1'b1, $sformatf("stream%0d", i));
        end
        chk("stream level", 32'(level), 32'd5);

        // Full plus one read: read frees a slot, pending word enters next cycle.
        for (int i = 0; i < 11; i++) cycle(1'b1, 1'b1, 8'(8'hD0 + i), 1'b0, $sformatf("refill%0d", i));
        chk("refill full", 32'(din_tready), 32'd0);
        cycle(1'b1, 1'b1, 8'hEE, 1'b1, "full+read");
        chk("after read level", 32'(level), 32'd15);
        chk("after read tready", 32'(din_tready), 32'd1);
        cycle(1'b1, 1'b1, 8'hEE, 1'b0, "pending in");
        chk("pending level", 32'(level), 32'd16);

        // Reset mid-operation at level 7, then 8'h3C must be the next output.
        cycle(1'b0, 1'b0, 8'h00, 1'b0, "mid rst0");
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 8'(8'h60 + i), 1'b0, $sformatf("mid%0d", i));
        cycle(1'b1, 1'b1, 8'h70, 1'b1, "mid sim0");
        cycle(1'b1, 1'b1, 8'h71, 1'b1, "mid sim1");
        chk("mid level 7", 32'(level), 32'd7);
        cycle(1'b0, 1'b1, 8'h72, 1'b1, "mid rst");
        chk("mid rst level", 32'(level), 32'd0);
        chk("mid rst tvalid", 32'(dout_tvalid), 32'd0);
        chk("mid rst tready", 32'(din_tready), 32'd1);
        cycle(1'b1, 1'b1, 8'h3C, 1'b0, "post rst wr");
        chk("post rst head", 32'(dout_tdata), 32'h3C);
        cycle(1'b1, 1'b0, 8'h00, 1'b1, "post rst rd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
